// File: rtl/bp_me_mem_cmd_arbiter_pkg.sv
// Shared helpers for the memory command arbiter slice.
// Messages stay opaque vectors, so this package only carries sizing helpers.
package bp_me_mem_cmd_arbiter_pkg;

  // Width of an index into n things. It never returns 0, so a one-element
  // structure still gets a legal 1-bit index.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_mem_cmd_arbiter_rr.sv
// Round-robin pointer plus masked priority encoder.
//   clk_i, reset_i  clock, async active-high reset (pointer -> 0)
//   en_i            a grant may be issued this cycle
//   v_i             request valid per requester
//   grant_v_o       a grant is issued this cycle
//   grant_id_o      winning requester index
//   yumi_o          one-hot grant (zero when no grant)
module bp_me_mem_cmd_arbiter_rr
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p = 2,
  localparam int lg_lp    = safe_clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 en_i,
  input  logic [num_req_p-1:0] v_i,
  output logic                 grant_v_o,
  output logic [lg_lp-1:0]     grant_id_o,
  output logic [num_req_p-1:0] yumi_o
);

  // Explicit wrap compare: num_req_p need not be a power of two.
  localparam logic [lg_lp-1:0] last_lp = lg_lp'(num_req_p - 1);

  logic [lg_lp-1:0] ptr_r;
  logic [lg_lp-1:0] idx, win;
  logic             found;

  // Walk from the pointer upward with wrap; the first valid wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr_r;
    for (int k = 0; k < num_req_p; k++) begin
      if (!found && v_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == last_lp) ? '0 : idx + 1'b1;
    end
  end

  assign grant_v_o  = en_i & found;
  assign grant_id_o = win;

  always_comb begin
    yumi_o = '0;
    for (int i = 0; i < num_req_p; i++)
      yumi_o[i] = grant_v_o & (win == lg_lp'(i));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      ptr_r <= '0;
    else if (grant_v_o)
      ptr_r <= (win == last_lp) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with valid/ready on the write side and
// valid/yumi on the read side. Async-reset flops throughout.
//   clk_i, reset_i   clock, async active-high reset (empties the FIFO)
//   v_i/ready_o      write valid / space available (full blocks, no bypass)
//   data_i           write data
//   v_o/data_o       head valid / head data
//   yumi_i           head consumed
module bsg_fifo_1r1w_small
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = safe_clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  logic [els_p-1:0][width_p-1:0] mem_r;
  logic [ptr_w_lp-1:0]           rd_r, wr_r;
  logic [cnt_w_lp-1:0]           cnt_r;
  logic                          enq, deq;

  // Full is judged on current occupancy only: a pop this cycle does not
  // make room for a push this cycle.
  assign ready_o = (cnt_r != full_lp);
  assign v_o     = (cnt_r != '0);
  assign data_o  = mem_r[rd_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_r <= '0;
      rd_r  <= '0;
      wr_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (enq) begin
        mem_r[wr_r] <= data_i;
        wr_r        <= (wr_r == last_lp) ? '0 : wr_r + 1'b1;
      end
      if (deq)
        rd_r <= (rd_r == last_lp) ? '0 : rd_r + 1'b1;
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Shares one BedRock mem_cmd/mem_resp port among num_req_p cache engines.
// Commands are round-robin arbitrated into a one-entry output register; the
// winner ids are queued in issue order so in-order memory responses can be
// steered back to the requester at the head of that queue.
//   clk_i, reset_i        clock, async active-high reset
//   req_mem_cmd_i         requester commands, requester i in slice i
//   req_mem_cmd_v_i       command valid per requester
//   req_mem_cmd_yumi_o    command consumed (one-hot or zero, combinational)
//   req_mem_resp_o        memory response, broadcast to all requesters
//   req_mem_resp_v_o      response valid (one-hot to the head requester)
//   req_mem_resp_yumi_i   response consumed per requester (head only counts)
//   mem_cmd_o/_v_o        registered command to memory
//   mem_cmd_ready_i       memory accepts the command
//   mem_resp_i/_v_i       memory response
//   mem_resp_yumi_o       memory response consumed
module bp_me_mem_cmd_arbiter
  import bp_me_mem_cmd_arbiter_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int mem_msg_width_p   = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p*mem_msg_width_p-1:0] req_mem_cmd_i,
  input  logic [num_req_p-1:0]                 req_mem_cmd_v_i,
  output logic [num_req_p-1:0]                 req_mem_cmd_yumi_o,
  output logic [mem_msg_width_p-1:0]           req_mem_resp_o,
  output logic [num_req_p-1:0]                 req_mem_resp_v_o,
  input  logic [num_req_p-1:0]                 req_mem_resp_yumi_i,
  output logic [mem_msg_width_p-1:0]           mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,
  input  logic [mem_msg_width_p-1:0]           mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o
);

  localparam int lg_lp = safe_clog2(num_req_p);

  logic [num_req_p-1:0][mem_msg_width_p-1:0] cmd_arr;
  logic [mem_msg_width_p-1:0]                cmd_r;
  logic                                      cmd_v_r;
  logic                                      slot_free, can_issue;
  logic                                      grant_v;
  logic [lg_lp-1:0]                          grant_id;
  logic                                      id_ready, id_v;
  logic [lg_lp-1:0]                          head;
  logic                                      resp_v;

  assign cmd_arr = req_mem_cmd_i;

  // ---------------- command side ----------------
  // The register can take a new command when it is empty or draining now.
  assign slot_free = ~cmd_v_r | mem_cmd_ready_i;
  assign can_issue = slot_free & id_ready;

  bp_me_mem_cmd_arbiter_rr #(.num_req_p(num_req_p)) rr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (can_issue),
    .v_i        (req_mem_cmd_v_i),
    .grant_v_o  (grant_v),
    .grant_id_o (grant_id),
    .yumi_o     (req_mem_cmd_yumi_o)
  );

  // Data is left untouched on drain so mem_cmd_o only changes on a load.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cmd_v_r <= 1'b0;
      cmd_r   <= '0;
    end else if (grant_v) begin
      cmd_v_r <= 1'b1;
      cmd_r   <= cmd_arr[grant_id];
    end else if (mem_cmd_ready_i) begin
      cmd_v_r <= 1'b0;
    end
  end

  assign mem_cmd_o   = cmd_r;
  assign mem_cmd_v_o = cmd_v_r;

  // ---------------- response side ----------------
  bsg_fifo_1r1w_small #(.width_p(lg_lp), .els_p(max_outstanding_p)) id_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (grant_v),
    .ready_o (id_ready),
    .data_i  (grant_id),
    .v_o     (id_v),
    .data_o  (head),
    .yumi_i  (mem_resp_yumi_o)
  );

  // A response with nothing outstanding is never steered or consumed.
  assign resp_v         = mem_resp_v_i & id_v;
  assign req_mem_resp_o = mem_resp_i;

  always_comb begin
    req_mem_resp_v_o = '0;
    mem_resp_yumi_o  = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      req_mem_resp_v_o[i] = resp_v & (head == lg_lp'(i));
      mem_resp_yumi_o     = mem_resp_yumi_o
                          | (resp_v & (head == lg_lp'(i)) & req_mem_resp_yumi_i[i]);
    end
  end

  // Memory answering with no command outstanding breaks the in-order contract.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(mem_resp_v_i && !id_v))
        else $error("bp_me_mem_cmd_arbiter: mem_resp_v_i with no outstanding command");
  end

endmodule
